// File: rtl/elevator_call_panel.sv
// Elevator call panel: latches floor-call buttons and issues one target floor
// at a time to the elevator controller. Targets follow SCAN order, so the car
// keeps its direction while calls remain ahead of it. A call is cleared when the
// car stands at its floor. A watchdog raises a sticky fault if the car never arrives.
module elevator_call_panel #(
    parameter  int FLOOR_W    = 2,
    localparam int NUM_FLOORS = 2**FLOOR_W - 1,
    parameter  int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  moving,
    output logic [FLOOR_W-1:0]    request,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  served,
    output logic                  fault
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

    // One-hot call mask for a floor code; code 0 (below floor 1) maps to no bit.
    function automatic logic [NUM_FLOORS-1:0] code_mask(input logic [FLOOR_W-1:0] code);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            if (code == f[FLOOR_W-1:0]) m[f-1] = 1'b1;
        end
        return m;
    endfunction

    state_t                r_state, w_state_nxt;
    logic                  r_dir_up, w_dir_up_nxt;
    logic [FLOOR_W-1:0]    r_request, w_request_nxt;
    logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt;
    logic                  r_served, w_served_nxt;
    logic                  r_fault, w_fault_nxt;
    logic [TMR_W-1:0]      r_timer, w_timer_nxt;

    logic [NUM_FLOORS-1:0] w_floor_mask;
    logic [NUM_FLOORS-1:0] w_target_mask;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clear;
    logic [FLOOR_W-1:0]    w_up_tgt;
    logic [FLOOR_W-1:0]    w_dn_tgt;
    logic                  w_here_pend;
    logic                  w_search_up;

    assign w_floor_mask  = code_mask(floor);
    assign w_target_mask = code_mask(r_request);
    assign w_here_pend   = |(r_pending & w_floor_mask);
    // A car reported at code 0 sits below floor 1, so the only useful direction is up.
    assign w_search_up   = (floor == '0) ? 1'b1 : r_dir_up;

    // Find the nearest pending floor above and below the car; 0 means none.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
        w_up_tgt = '0;
        w_dn_tgt = '0;
        for (int f = NUM_FLOORS; f >= 1; f--) begin
            if (r_pending[f-1] && (f[FLOOR_W-1:0] > floor)) w_up_tgt = f[FLOOR_W-1:0];
        end
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            if (r_pending[f-1] && (f[FLOOR_W-1:0] < floor)) w_dn_tgt = f[FLOOR_W-1:0];
        end
    end

    // Next-state, target selection, call set/clear and watchdog.
    always_comb begin
        w_state_nxt   = r_state;
        w_dir_up_nxt  = r_dir_up;
        w_request_nxt = r_request;
        w_fault_nxt   = r_fault;
        w_timer_nxt   = '0;
        w_served_nxt  = 1'b0;
        w_set         = btn;
        w_clear       = '0;

        // A press for the floor the idle car already stands at is answered at once.
        if ((r_state == S_IDLE) && !moving && |(btn & w_floor_mask)) begin
            w_set        = btn & ~w_floor_mask;
            w_served_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_dir_up_nxt = w_search_up;
                    if (w_here_pend && !moving) begin
                        w_clear      = w_floor_mask;
                        w_served_nxt = 1'b1;
                    end else if (w_here_pend) begin
                        // Still rolling through a pending floor: target it and let arrival/watchdog decide.
                        w_request_nxt = floor;
                        w_state_nxt   = S_BUSY;
                    end else begin
                        w_state_nxt = S_BUSY;
                        if (w_search_up) begin
                            if (w_up_tgt != '0) begin
                                w_request_nxt = w_up_tgt;
                            end else begin
                                w_request_nxt = w_dn_tgt;
                                w_dir_up_nxt  = 1'b0;
                            end
                        end else begin
                            if (w_dn_tgt != '0) begin
                                w_request_nxt = w_dn_tgt;
                            end else begin
                                w_request_nxt = w_up_tgt;
                                w_dir_up_nxt  = 1'b1;
                            end
                        end
                    end
                end
            end
            S_BUSY: begin
                if ((floor == r_request) && !moving) begin
                    w_clear       = w_target_mask;
                    w_served_nxt  = 1'b1;
                    w_request_nxt = '0;
                    w_state_nxt   = S_GAP;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    // Give up on this trip but keep the call so the next selection retries it.
                    w_fault_nxt   = 1'b1;
                    w_request_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_request_nxt = '0;
            end
        endcase

        // Clear is applied after set so a re-press on the arrival edge does not survive.
        w_pending_nxt = (r_pending | w_set) & ~w_clear;
    end

    // State and output registers; reset drops the request immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_dir_up  <= 1'b1;
            r_request <= '0;
            r_pending <= '0;
            r_served  <= 1'b0;
            r_fault   <= 1'b0;
            r_timer   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values together.
            r_state   <= w_state_nxt;
            r_dir_up  <= w_dir_up_nxt;
            r_request <= w_request_nxt;
            r_pending <= w_pending_nxt;
            r_served  <= w_served_nxt;
            r_fault   <= w_fault_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

    assign request = r_request;
    assign pending = r_pending;
    assign served  = r_served;
    assign fault   = r_fault;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Testbench for elevator_call_panel: a reference model predicts the panel
// outputs after every clock edge and queues them. A monitor compares the queued
// values with the DUT on the falling edge. Directed scenarios come first, then
// random calls against an emulated car.
module tb_elevator_call_panel;

    localparam int FW = 2;
    localparam int NF = 3;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NF-1:0] btn;
    logic [FW-1:0] floor;
    logic          moving;
    logic [FW-1:0] request;
    logic [NF-1:0] pending;
    logic          served;
    logic          fault;

    elevator_call_panel #(.FLOOR_W(FW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn),
        .floor   (floor),
        .moving  (moving),
        .request (request),
        .pending (pending),
        .served  (served),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int req;
        int pend;
        bit srv;
        bit flt;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_s;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: calls as a set of floors, direction as +1/-1, and a trip
    // described by its target floor (0 = none), a gap flag and a cycle count.
    bit calls[1:NF];
    int m_dir, m_target, m_busy;
    bit m_gap, m_flt, m_srv;

    function automatic int calls_vec();
        int v = 0;
        for (int f = 1; f <= NF; f++) if (calls[f]) v += (1 << (f - 1));
        return v;
    endfunction

    function automatic int look(input int fl, input int d);
        for (int f = fl + d; f >= 1 && f <= NF; f += d) if (calls[f]) return f;
        return 0;
    endfunction

    task automatic model_reset();
        for (int f = 1; f <= NF; f++) calls[f] = 0;
        m_dir = 1; m_target = 0; m_busy = 0; m_gap = 0; m_flt = 0; m_srv = 0;
    endtask

    task automatic model_edge(input int b, input int fl, input bit mv);
        bit press[1:NF];
        int clr, t;
        bit idle, n_srv;
        clr   = 0;
        n_srv = 0;
        for (int f = 1; f <= NF; f++) press[f] = ((b >> (f - 1)) & 1) != 0;
        idle = (m_target == 0) && !m_gap;
        if (idle && !mv && fl >= 1 && press[fl]) begin
            press[fl] = 0;
            n_srv     = 1;
        end
        if (m_gap) begin
            m_gap = 0;
        end else if (m_target != 0) begin
            if (fl == m_target && !mv) begin
                clr = m_target; n_srv = 1; m_target = 0; m_gap = 1; m_busy = 0;
            end else if (m_busy == TO - 1) begin
                m_flt = 1; m_target = 0; m_busy = 0;
            end else begin
                m_busy++;
            end
        end else if (calls_vec() != 0) begin
            if (fl == 0) m_dir = 1;
            if (fl >= 1 && calls[fl]) begin
                if (!mv) begin
                    clr = fl; n_srv = 1;
                end else begin
                    m_target = fl; m_busy = 0;
                end
            end else begin
                t = look(fl, m_dir);
                if (t == 0) begin
                    m_dir = -m_dir;
                    t     = look(fl, m_dir);
                end
                m_target = t;
                m_busy   = 0;
            end
        end
        for (int f = 1; f <= NF; f++) if (press[f]) calls[f] = 1;
        if (clr != 0) calls[clr] = 0;
        m_srv = n_srv;
    endtask

    // Drive one cycle of inputs, advance the model over the edge, queue the expectation.
    task automatic step(input int b, input int fl, input bit mv);
        btn    = b[NF-1:0];
        floor  = fl[FW-1:0];
        moving = mv;
        @(posedge clk);
        model_edge(b, fl, mv);
        exp_q.push_back('{req: m_target, pend: calls_vec(), srv: m_srv, flt: m_flt});
        #2;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && exp_q.size() != 0) begin
            mon_s = exp_q.pop_front();
            check("request", int'(request), mon_s.req);
            check("pending", int'(pending), mon_s.pend);
            check("served",  int'(served),  mon_s.srv);
            check("fault",   int'(fault),   mon_s.flt);
        end
    end

    int car_fl, car_goal, car_cnt, car_stall, rb;
    bit car_mv;

    initial begin
        btn = '0; floor = 2'd1; moving = 1'b0;
        reset_n = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        check("reset_request", int'(request), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_served",  int'(served),  0);
        check("reset_fault",   int'(fault),   0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 reset_n = 1'b1;

        // Single call: latch, target two edges after press, arrival, gap.
        step(3'b010, 1, 0);  check("t1_pending_latched", int'(pending), 2);
        step(0, 1, 0);       check("t1_request", int'(request), 2);
        step(0, 2, 0);       check("t1_served", int'(served), 1);
                             check("t1_cleared", int'(pending), 0);
        step(0, 2, 0);       check("t1_gap_request", int'(request), 0);
                             check("t1_served_once", int'(served), 0);

        // Own-floor call served at once, far call targeted after.
        step(0, 1, 0);
        step(3'b101, 1, 0);  check("t2_same_floor_served", int'(served), 1);
                             check("t2_pending", int'(pending), 4);
        step(0, 1, 0);       check("t2_request", int'(request), 3);
        step(0, 2, 1);
        step(0, 2, 1);
        step(0, 3, 0);       check("t2_arrival", int'(served), 1);
        step(0, 3, 0);       check("t2_request_after", int'(request), 0);

        // Direction flip, and no retarget while busy.
        step(0, 2, 0);
        step(0, 2, 0);
        step(3'b001, 2, 0);
        step(0, 2, 0);       check("t3_flip_request", int'(request), 1);
        step(3'b100, 2, 1);  check("t3_no_retarget", int'(request), 1);
        step(0, 1, 1);
        step(0, 1, 0);       check("t3_pending_left", int'(pending), 4);
        step(0, 1, 0);
        step(0, 1, 0);       check("t3_next_request", int'(request), 3);
        step(0, 3, 0);
        step(0, 3, 0);

        // Watchdog: car never stops.
        step(3'b010, 3, 0);
        step(0, 3, 0);       check("t4_request", int'(request), 2);
        repeat (TO - 1) step(0, 3, 1);
        check("t4_fault_not_yet", int'(fault), 0);
        step(0, 3, 1);       check("t4_fault", int'(fault), 1);
                             check("t4_request_dropped", int'(request), 0);
                             check("t4_pending_kept", int'(pending), 2);
        step(0, 3, 1);       check("t4_retry", int'(request), 2);
        step(0, 2, 0);       check("t4_served", int'(served), 1);
                             check("t4_fault_sticky", int'(fault), 1);
        step(0, 2, 0);

        // Arrival edge coincides with a re-press of the target floor.
        step(3'b001, 2, 0);
        step(0, 2, 0);
        step(3'b001, 1, 0);  check("t6_clear_wins", int'(pending), 0);
                             check("t6_served", int'(served), 1);
        step(0, 1, 0);       check("t6_served_once", int'(served), 0);
        step(0, 1, 0);

        // Car reported below floor 1.
        step(3'b010, 0, 0);
        step(0, 0, 0);       check("floor0_request", int'(request), 2);
        step(0, 2, 0);
        step(0, 2, 0);

        // Asynchronous reset in the middle of a trip.
        step(3'b100, 2, 0);
        step(0, 2, 0);
        step(3'b001, 2, 1);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("t5_request", int'(request), 0);
        check("t5_pending", int'(pending), 0);
        check("t5_served",  int'(served),  0);
        check("t5_fault",   int'(fault),   0);
        @(posedge clk);
        @(negedge clk); #1 reset_n = 1'b1;
        model_reset();
        step(0, 1, 0);
        step(0, 1, 0);       check("t5_idle_request", int'(request), 0);
        step(3'b010, 1, 0);
        step(0, 1, 0);       check("t5_new_request", int'(request), 2);

        // Random calls against an emulated car that occasionally stalls.
        car_fl = 1; car_mv = 0; car_goal = 0; car_cnt = 0; car_stall = 0;
        for (int i = 0; i < 3000; i++) begin
            rb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : 0;
            step(rb, car_fl, car_mv);
            if (car_goal == 0 && m_target != 0) begin
                car_goal  = m_target;
                car_cnt   = 0;
                car_stall = ($urandom_range(0, 4) == 0) ? 12 : 0;
            end
            if (car_goal != 0) begin
                if (car_fl == car_goal) begin
                    car_mv = 0; car_goal = 0;
                end else begin
                    car_mv = 1;
                    if (car_stall > 0) begin
                        car_stall--;
                    end else begin
                        car_cnt++;
                        if (car_cnt == 3) begin
                            car_cnt = 0;
                            car_fl += (car_goal > car_fl) ? 1 : -1;
                            if (car_fl == car_goal) begin
                                car_mv = 0; car_goal = 0;
                            end
                        end
                    end
                end
            end
        end

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
